// File: rtl/program_completion_monitor.sv
// Watches the fetched instruction stream for the jal x0,0 halt self-loop, waits for L1 to drain,
// then raises a sticky program_done. Also provides saturating cycle and fetch counters.
module program_completion_monitor #(
    parameter int             n            = 32,
    parameter int             CNT_W        = 32,
    parameter logic [n-1:0]   HALT_INSTR   = n'(32'h0000006f),
    parameter int             HALT_CONFIRM = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             L1_busy,
    input  logic [n-1:0]     instruction,
    input  logic             instr_valid,
    output logic             program_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_WAIT_L1,
        S_RUN,
        S_HALT_SEEN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] CONFIRM_TARGET = 4'(HALT_CONFIRM);

    state_t           state_q, state_d;
    logic [3:0]       confirm_q, confirm_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             program_done_q, program_done_d;
    logic             halted_q, halted_d;

    logic             fetch_halt;
    logic             fetch_other;
    logic [3:0]       confirm_inc;

    // Counters stick at all-ones so a runaway program never reports a wrapped, tiny count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

    // The instruction is only looked at when valid, so X on an idle bus never reaches state.
    assign fetch_halt  = instr_valid && (instruction == HALT_INSTR);
    assign fetch_other = instr_valid && (instruction != HALT_INSTR);
    assign confirm_inc = confirm_q + 4'd1;

    always_comb begin
        state_d        = state_q;
        confirm_d      = confirm_q;
        cycle_count_d  = cycle_count_q;
        instr_count_d  = instr_count_q;

        case (state_q)
            S_WAIT_L1: begin
                if (!L1_busy) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (instr_valid) begin
                    instr_count_d = sat_inc(instr_count_q);
                end
                if (fetch_halt) begin
                    confirm_d = 4'd1;
                    state_d   = (CONFIRM_TARGET == 4'd1) ? S_DRAIN : S_HALT_SEEN;
                end
            end

            // A non-halt fetch here means the loop was a look-alike the core branched out of.
            S_HALT_SEEN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (instr_valid) begin
                    instr_count_d = sat_inc(instr_count_q);
                end
                if (fetch_halt) begin
                    confirm_d = confirm_inc;
                    if (confirm_inc == CONFIRM_TARGET) begin
                        state_d = S_DRAIN;
                    end
                end else if (fetch_other) begin
                    confirm_d = 4'd0;
                    state_d   = S_RUN;
                end
            end

            S_DRAIN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (!L1_busy) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_WAIT_L1;
            end
        endcase

        // Flags are registered from the next state so they line up with the state register.
        program_done_d = (state_d == S_DONE);
        halted_d       = (state_d == S_DRAIN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_WAIT_L1;
            confirm_q      <= 4'd0;
            cycle_count_q  <= '0;
            instr_count_q  <= '0;
            program_done_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            confirm_q      <= confirm_d;
            cycle_count_q  <= cycle_count_d;
            instr_count_q  <= instr_count_d;
            program_done_q <= program_done_d;
            halted_q       <= halted_d;
        end
    end

    assign program_done = program_done_q;
    assign halted       = halted_q;
    assign cycle_count  = cycle_count_q;
    assign instr_count  = instr_count_q;

endmodule

// File: doc/program_completion_monitor.md
Name: program_completion_monitor

Overview:
- Sits directly downstream of the RISC-V core's fetch path, alongside the top-level. Consumes the fetched instruction stream and the L1 busy flag.
- Detects the end-of-program self-loop (jal x0,0 = 32'h0000006f), waits for L1 to go idle, then raises a sticky program_done.
- Provides cycle and retired-fetch counters, so elapsed time is measured in hardware rather than by the bench.

Parameters:
- n, 32, instruction width.
- CNT_W, 32, width of cycle_count and instr_count.
- HALT_INSTR, 32'h0000006f, encoding of the halt self-loop.
- HALT_CONFIRM, 2, number of consecutive valid halt fetches needed to declare halt (range 1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- L1_busy  input  1  high while L1 is initialising or has an outstanding transaction.
- instruction  input  n  instruction currently fetched by the core.
- instr_valid  input  1  high for exactly one cycle per new fetch; instruction is sampled only when this is high.
- program_done  output  1  sticky halt-and-drained indication.
- cycle_count  output  CNT_W  cycles elapsed since L1 first became idle.
- instr_count  output  CNT_W  valid fetches counted while running.
- halted  output  1  high in DRAIN and DONE.

Behaviour:
- Reset (async, immediate):
  - State = WAIT_L1.
  - program_done = 0, halted = 0, cycle_count = 0, instr_count = 0, confirm counter = 0.
  - All outputs are registered.
- WAIT_L1:
  - Counters hold and instr_valid is ignored.
  - When L1_busy = 0 at a rising edge, go to RUN.
  - Counting begins on the first edge spent in RUN.
- RUN:
  - cycle_count += 1 every cycle.
  - On instr_valid: instr_count += 1.
  - If instruction == HALT_INSTR: confirm = 1. Go to DRAIN if HALT_CONFIRM == 1, otherwise go to HALT_SEEN.
  - Any other instruction: stay in RUN.
- HALT_SEEN:
  - cycle_count += 1 every cycle.
  - On instr_valid: instr_count += 1.
  - Halt fetch: confirm += 1; when confirm reaches HALT_CONFIRM, go to DRAIN.
  - Non-halt fetch: confirm = 0 and return to RUN (a branch out of a look-alike).
  - Cycles without instr_valid leave confirm unchanged.
- DRAIN:
  - halted = 1, cycle_count += 1, instr_valid ignored.
  - When L1_busy = 0 at an edge, go to DONE.
  - If L1_busy is already 0 on entry, exactly one cycle is spent in DRAIN.
- DONE:
  - program_done = 1 and halted = 1.
  - All counters are frozen.
  - State is sticky until reset; inputs are ignored.
- Counter saturation: cycle_count and instr_count saturate at all-ones and never wrap.
- L1_busy during RUN or HALT_SEEN has no effect on counting or transitions.
- Reset asserted mid-operation, including in DONE, returns immediately to the reset values above.
- X on instruction while instr_valid = 0 must not affect state.

Test Plan:
- Startup: reset pulse, L1_busy = 1 for 3 edges then 0 → state holds in WAIT_L1 with cycle_count = 0; RUN entered on the first edge with L1_busy = 0; cycle_count = 1 one edge later.
- Normal halt (HALT_CONFIRM = 2): 5 non-halt valid fetches, then two valid 0x0000006f fetches, L1_busy = 0 →
  - instr_count = 7.
  - halted = 1 the edge after the 2nd halt fetch.
  - program_done = 1 one edge after that.
- False halt: a single 0x0000006f fetch followed by a valid 0x00e7a023 → returns to RUN, halted stays 0, instr_count increments for both fetches.
- Drain wait: halt confirmed while L1_busy = 1 for 4 more cycles →
  - halted = 1 and program_done = 0 through those cycles.
  - program_done = 1 on the edge after L1_busy falls.
  - cycle_count freezes at that value.
- Saturation (CNT_W = 4): run 20 cycles with a valid fetch every cycle → cycle_count = 15 and instr_count = 15, with no wrap.
- Mid-run reset: assert reset asynchronously between edges while in DONE → program_done, halted and the counters go to 0 immediately, without waiting for a clock edge; state returns to WAIT_L1.
